// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: arbitrates two writeback sources onto one register-file write port
// Ports:
//   Clk, Rst_n                  clock, synchronous active-low reset
//   A_valid/A_ready/A_reg/A_data  short-latency source handshake + payload
//   B_valid/B_ready/B_reg/B_data  long-latency source handshake + payload
//   Claim_valid/Claim_reg       issue-stage destination reservation
//   Reg_write/Write_reg/Write_data  registered register-file write port
//   Busy_mask                   per-register outstanding-producer scoreboard
module reg_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 3
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 A_valid,
    output logic                 A_ready,
    input  logic [ADDR_W-1:0]    A_reg,
    input  logic [DATA_W-1:0]    A_data,
    input  logic                 B_valid,
    output logic                 B_ready,
    input  logic [ADDR_W-1:0]    B_reg,
    input  logic [DATA_W-1:0]    B_data,
    input  logic                 Claim_valid,
    input  logic [ADDR_W-1:0]    Claim_reg,
    output logic                 Reg_write,
    output logic [ADDR_W-1:0]    Write_reg,
    output logic [DATA_W-1:0]    Write_data,
    output logic [2**ADDR_W-1:0] Busy_mask
);
    localparam int NR = 2**ADDR_W;
    localparam int CW = $clog2(STARVE_MAX+1);
    typedef enum logic {NORMAL, FORCE_B} state_t;
    state_t          state;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            force_b, a_xfer, b_xfer, xfer;
    logic [ADDR_W-1:0] w_reg;
    logic [DATA_W-1:0] w_data;
    logic [NR-1:0]   set, clr;
    always_comb begin
        force_b = state == FORCE_B;
        A_ready = Rst_n & A_valid & (~force_b | ~B_valid);
        B_ready = Rst_n & B_valid & (force_b | ~A_valid);
        a_xfer  = A_valid & A_ready;
        b_xfer  = B_valid & B_ready;
        xfer    = a_xfer | b_xfer;
        w_reg   = b_xfer ? B_reg : A_reg;
        w_data  = b_xfer ? B_data : A_data;
        cnt_nxt = (~B_valid | b_xfer) ? '0 : (cnt == CW'(STARVE_MAX)) ? cnt : cnt + 1'b1;
        // register 0 is never claimed, so bit 0 stays clear
        set     = (Claim_valid && Claim_reg != '0) ? NR'(1) << Claim_reg : '0;
        clr     = Reg_write ? NR'(1) << Write_reg : '0;
    end
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state      <= NORMAL;
            cnt        <= '0;
            Reg_write  <= 1'b0;
            Write_reg  <= '0;
            Write_data <= '0;
            Busy_mask  <= '0;
        end else begin
            cnt        <= cnt_nxt;
            state      <= force_b ? ((b_xfer | ~B_valid) ? NORMAL : FORCE_B)
                                  : ((cnt_nxt == CW'(STARVE_MAX)) ? FORCE_B : NORMAL);
            Reg_write  <= xfer & (w_reg != '0);
            Write_reg  <= xfer ? w_reg : Write_reg;
            Write_data <= xfer ? w_data : Write_data;
            // a claim in the same cycle as the clearing write wins: newer producer pending
            Busy_mask  <= (Busy_mask & ~clr) | set;
        end
    end
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter: directed and randomized checks against a behavioural model
module tb_reg_wb_arbiter;
    localparam int DW = 32, AW = 5, SM = 3, NR = 32;
    logic          Clk = 0, Rst_n = 0;
    logic          A_valid = 0, B_valid = 0, Claim_valid = 0;
    logic          A_ready, B_ready, Reg_write;
    logic [AW-1:0] A_reg = 0, B_reg = 0, Claim_reg = 0, Write_reg;
    logic [DW-1:0] A_data = 0, B_data = 0, Write_data;
    logic [NR-1:0] Busy_mask;
    int checks = 0, failures = 0;
    int wait_b = 0;
    logic          m_rw = 0, m_ga = 0, m_gb = 0;
    logic [AW-1:0] m_wr = 0;
    logic [DW-1:0] m_wd = 0;
    logic [NR-1:0] m_busy = 0;

    reg_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(SM)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .A_valid(A_valid), .A_ready(A_ready), .A_reg(A_reg), .A_data(A_data),
        .B_valid(B_valid), .B_ready(B_ready), .B_reg(B_reg), .B_data(B_data),
        .Claim_valid(Claim_valid), .Claim_reg(Claim_reg),
        .Reg_write(Reg_write), .Write_reg(Write_reg), .Write_data(Write_data),
        .Busy_mask(Busy_mask)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check handshake outputs, advance the model at the edge, check registered outputs.
    task automatic cycle();
        logic f;
        #1;
        f    = wait_b >= SM;
        m_ga = Rst_n & A_valid & (!f | !B_valid);
        m_gb = Rst_n & B_valid & (f | !A_valid);
        chk("A_ready", {63'd0, A_ready}, {63'd0, m_ga});
        chk("B_ready", {63'd0, B_ready}, {63'd0, m_gb});
        @(posedge Clk);
        if (!Rst_n) begin
            m_rw = 0; m_wr = 0; m_wd = 0; m_busy = 0; wait_b = 0;
        end else begin
            if (m_rw) m_busy[m_wr] = 1'b0;
            if (Claim_valid && Claim_reg != 0) m_busy[Claim_reg] = 1'b1;
            if (m_ga || m_gb) begin
                m_wr = m_gb ? B_reg : A_reg;
                m_wd = m_gb ? B_data : A_data;
                m_rw = m_wr != 0;
            end else m_rw = 0;
            wait_b = (!B_valid || m_gb) ? 0 : (wait_b < SM ? wait_b + 1 : SM);
        end
        #1;
        chk("Reg_write", {63'd0, Reg_write}, {63'd0, m_rw});
        chk("Write_reg", {59'd0, Write_reg}, {59'd0, m_wr});
        chk("Write_data", {32'd0, Write_data}, {32'd0, m_wd});
        chk("Busy_mask", {32'd0, Busy_mask}, {32'd0, m_busy});
        @(negedge Clk);
    endtask

    initial begin
        @(negedge Clk);
        Rst_n = 0; A_valid = 1; B_valid = 1;
        cycle(); cycle();
        Rst_n = 1; A_valid = 0; B_valid = 0;
        cycle();
        chk("rst_reg_write", {63'd0, Reg_write}, 64'd0);
        chk("rst_busy", {32'd0, Busy_mask}, 64'd0);

        A_valid = 1; A_reg = 5; A_data = 32'hDEADBEEF;
        #1 chk("single_a_ready", {63'd0, A_ready}, 64'd1);
        cycle();
        chk("single_rw", {63'd0, Reg_write}, 64'd1);
        chk("single_wr", {59'd0, Write_reg}, 64'd5);
        chk("single_wd", {32'd0, Write_data}, 64'hDEADBEEF);
        A_valid = 0;
        cycle();
        chk("single_pulse", {63'd0, Reg_write}, 64'd0);

        A_valid = 1; B_valid = 1; A_reg = 1; B_reg = 2; A_data = 32'hA; B_data = 32'hB;
        for (int i = 0; i < 8; i++) begin
            #1 chk("aaab_b", {63'd0, B_ready}, {63'd0, i % 4 == 3});
            chk("aaab_a", {63'd0, A_ready}, {63'd0, i % 4 != 3});
            cycle();
        end
        A_valid = 0; B_valid = 0;
        cycle(); cycle();

        Claim_valid = 1; Claim_reg = 7;
        cycle();
        Claim_valid = 0;
        chk("sb_claim", {63'd0, Busy_mask[7]}, 64'd1);
        B_valid = 1; B_reg = 7; B_data = 32'h77;
        cycle();
        B_valid = 0;
        chk("sb_pending", {63'd0, Busy_mask[7]}, 64'd1);
        chk("sb_write7", {59'd0, Write_reg}, 64'd7);
        Claim_valid = 1;
        cycle();
        Claim_valid = 0;
        chk("sb_set_wins", {63'd0, Busy_mask[7]}, 64'd1);
        B_valid = 1;
        cycle();
        B_valid = 0;
        cycle();
        chk("sb_cleared", {63'd0, Busy_mask[7]}, 64'd0);

        A_valid = 1; A_reg = 0; A_data = 32'h1; Claim_valid = 1; Claim_reg = 0;
        #1 chk("r0_ready", {63'd0, A_ready}, 64'd1);
        cycle();
        A_valid = 0; Claim_valid = 0;
        chk("r0_rw", {63'd0, Reg_write}, 64'd0);
        chk("r0_wd", {32'd0, Write_data}, 64'd1);
        chk("r0_busy", {63'd0, Busy_mask[0]}, 64'd0);

        Claim_valid = 1; Claim_reg = 9;
        A_valid = 1; B_valid = 1; A_reg = 9; A_data = 32'h99;
        cycle();
        Claim_valid = 0;
        cycle(); cycle();
        Rst_n = 0;
        cycle();
        chk("mid_rst_rw", {63'd0, Reg_write}, 64'd0);
        chk("mid_rst_busy", {32'd0, Busy_mask}, 64'd0);
        Rst_n = 1;
        #1 chk("mid_rst_normal_a", {63'd0, A_ready}, 64'd1);
        chk("mid_rst_normal_b", {63'd0, B_ready}, 64'd0);
        cycle();

        for (int i = 0; i < 400; i++) begin
            Rst_n = ($urandom % 60) != 0;
            if (!(A_valid && !m_ga)) begin
                A_valid = ($urandom % 3) != 0;
                A_reg = AW'($urandom_range(0, 7));
                A_data = $urandom;
            end
            if (!(B_valid && !m_gb)) begin
                B_valid = ($urandom % 3) != 0;
                B_reg = AW'($urandom_range(0, 7));
                B_data = $urandom;
            end
            Claim_valid = $urandom % 2;
            Claim_reg = AW'($urandom_range(0, 7));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
